mmio_io_ctrl: RTL and testbench

- Parametrised memory-mapped I/O controller for the pipelined CPU. It replaces the hard-wired key, switch, LED and hex decode that currently sits in the core's M stage.
- Synchronises and debounces KEY and SW inputs, and captures sticky press and change events as write-1-to-clear status registers.
- Holds the HEX, LEDR and LEDG output registers.
- Presents one combinational read port and one synchronous write port at the CPU's M-stage data-memory interface.

---
 rtl/mmio_io_pkg.sv | 31 +++
 rtl/io_debounce.sv | 66 ++++++
 rtl/mmio_io_ctrl.sv | 154 +++++++++++++++
 tb/tb_mmio_io_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_io_pkg.sv
// Shared constants for the memory-mapped key/switch/LED/hex I/O block:
// register offsets inside the 8-word window, default read value, EVTEN bits.
package mmio_io_pkg;

  // Byte offsets from IOBASE (word stride 2)
  localparam logic [3:0] OFF_KEYDATA = 4'h0;
  localparam logic [3:0] OFF_SWDATA  = 4'h2;
  localparam logic [3:0] OFF_KEYSTAT = 4'h4;
  localparam logic [3:0] OFF_SWSTAT  = 4'h6;
  localparam logic [3:0] OFF_HEX     = 4'h8;
  localparam logic [3:0] OFF_LEDR    = 4'hA;
  localparam logic [3:0] OFF_LEDG    = 4'hC;
  localparam logic [3:0] OFF_EVTEN   = 4'hE;

  // Last byte offset that still belongs to the window
  localparam logic [3:0] OFF_LAST    = 4'hE;

  // Value returned for addresses outside the window
  localparam logic [15:0] RD_DEFAULT = 16'hDEAD;

  // EVTEN register layout
  localparam int EVTEN_W       = 2;
  localparam int EVTEN_KEY_BIT = 0;
  localparam int EVTEN_SW_BIT  = 1;

  // Event output term: an enable bit gating "any status bit pending"
  function automatic logic evt_term(input logic en, input logic any_pending);
    return en & any_pending;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// W-bit synchroniser + per-bit debouncer. Each bit has its own counter; deb
// only follows the synchronised input after DEB_CYCLES consecutive cycles of
// disagreement. pulse is a 1-cycle strobe aligned with the edge on which deb
// changes: rising edges only when RISE_ONLY, any change otherwise.
module io_debounce #(
  parameter int W          = 4,
  parameter int DEB_CYCLES = 4,
  parameter bit RISE_ONLY  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] deb,
  output logic [W-1:0] pulse
);

  localparam int            CW       = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [W-1:0]          meta_q, meta_d;
  logic [W-1:0]          sync_q, sync_d;
  logic [W-1:0]          deb_q, deb_d;
  logic [W-1:0][CW-1:0]  cnt_q, cnt_d;

  // Next-state for synchroniser, counters and debounced level, plus edge strobe
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    pulse  = '0;
    for (int i = 0; i < W; i++) begin
      if (sync_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    if (RISE_ONLY) begin
      pulse = deb_d & ~deb_q;
    end else begin
      pulse = deb_d ^ deb_q;
    end
  end

  // State registers; reset discards any partial debounce count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller at the M-stage data-memory port: debounced
// keys/switches with sticky W1C status, HEX/LEDR/LEDG output registers and an
// event line. Reads are combinational from ADDR; writes land on the CLK edge.
module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter int               DBITS          = 16,
  parameter int               NKEYS          = 4,
  parameter int               NSW            = 10,
  parameter int               NLEDR          = 10,
  parameter int               NLEDG          = 8,
  parameter int               NHEX           = 4,
  parameter int               DEB_CYCLES     = 50000,
  parameter int               KEY_ACTIVE_LOW = 1,
  parameter logic [DBITS-1:0] IOBASE         = 16'hFFF0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DBITS-1:0]  ADDR,
  input  logic              WE,
  input  logic [DBITS-1:0]  WDATA,
  output logic [DBITS-1:0]  RDATA,
  output logic              HIT,
  input  logic [NKEYS-1:0]  KEY,
  input  logic [NSW-1:0]    SW,
  output logic [NLEDR-1:0]  LEDR,
  output logic [NLEDG-1:0]  LEDG,
  output logic [4*NHEX-1:0] HEXVAL,
  output logic              EVT
);

  logic [NKEYS-1:0]  key_in_s, key_deb_s, key_rise_s, key_clr_s;
  logic [NSW-1:0]    sw_deb_s, sw_chg_s, sw_clr_s;
  logic [NKEYS-1:0]  keystat_q, keystat_d;
  logic [NSW-1:0]    swstat_q, swstat_d;
  logic [4*NHEX-1:0] hex_q, hex_d;
  logic [NLEDR-1:0]  ledr_q, ledr_d;
  logic [NLEDG-1:0]  ledg_q, ledg_d;
  logic [EVTEN_W-1:0] evten_q, evten_d;
  logic              evt_q, evt_d;
  logic [DBITS-1:0]  off_s, off_al_s;
  logic              hit_s, wr_s;

  // Keys are normalised so that 1 always means pressed
  assign key_in_s = (KEY_ACTIVE_LOW != 0) ? ~KEY : KEY;

  io_debounce #(
    .W          (NKEYS),
    .DEB_CYCLES (DEB_CYCLES),
    .RISE_ONLY  (1'b1)
  ) u_key_deb (
    .clk   (CLK),
    .rst   (RESET),
    .din   (key_in_s),
    .deb   (key_deb_s),
    .pulse (key_rise_s)
  );

  io_debounce #(
    .W          (NSW),
    .DEB_CYCLES (DEB_CYCLES),
    .RISE_ONLY  (1'b0)
  ) u_sw_deb (
    .clk   (CLK),
    .rst   (RESET),
    .din   (SW),
    .deb   (sw_deb_s),
    .pulse (sw_chg_s)
  );

  // Window decode; odd addresses are aligned down to their word
  always_comb begin
    hit_s    = (ADDR >= IOBASE) && (ADDR <= (IOBASE + DBITS'(OFF_LAST)));
    off_s    = ADDR - IOBASE;
    off_al_s = off_s & ~DBITS'(1);
  end

  // Combinational read mux, zero-extending narrow registers
  always_comb begin
    RDATA = DBITS'(RD_DEFAULT);
    if (hit_s) begin
      case (off_al_s)
        DBITS'(OFF_KEYDATA): RDATA = DBITS'(key_deb_s);
        DBITS'(OFF_SWDATA):  RDATA = DBITS'(sw_deb_s);
        DBITS'(OFF_KEYSTAT): RDATA = DBITS'(keystat_q);
        DBITS'(OFF_SWSTAT):  RDATA = DBITS'(swstat_q);
        DBITS'(OFF_HEX):     RDATA = DBITS'(hex_q);
        DBITS'(OFF_LEDR):    RDATA = DBITS'(ledr_q);
        DBITS'(OFF_LEDG):    RDATA = DBITS'(ledg_q);
        DBITS'(OFF_EVTEN):   RDATA = DBITS'(evten_q);
        default:             RDATA = DBITS'(RD_DEFAULT);
      endcase
    end else begin
      RDATA = DBITS'(RD_DEFAULT);
    end
  end

  assign HIT = hit_s;

  // Write decode, W1C status update (set beats clear) and event term
  always_comb begin
    wr_s      = WE & hit_s;
    hex_d     = hex_q;
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
    evten_d   = evten_q;
    key_clr_s = '0;
    sw_clr_s  = '0;
    if (wr_s) begin
      case (off_al_s)
        DBITS'(OFF_KEYSTAT): key_clr_s = WDATA[NKEYS-1:0];
        DBITS'(OFF_SWSTAT):  sw_clr_s  = WDATA[NSW-1:0];
        DBITS'(OFF_HEX):     hex_d     = WDATA[4*NHEX-1:0];
        DBITS'(OFF_LEDR):    ledr_d    = WDATA[NLEDR-1:0];
        DBITS'(OFF_LEDG):    ledg_d    = WDATA[NLEDG-1:0];
        DBITS'(OFF_EVTEN):   evten_d   = WDATA[EVTEN_W-1:0];
        default:             hex_d     = hex_q;  // KEYDATA/SWDATA are read-only
      endcase
    end else begin
      key_clr_s = '0;
    end
    keystat_d = (keystat_q & ~key_clr_s) | key_rise_s;
    swstat_d  = (swstat_q  & ~sw_clr_s)  | sw_chg_s;
    evt_d     = evt_term(evten_q[EVTEN_KEY_BIT], |keystat_q) |
                evt_term(evten_q[EVTEN_SW_BIT],  |swstat_q);
  end

  // Architectural registers; EVT trails the status registers by one cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      keystat_q <= '0;
      swstat_q  <= '0;
      hex_q     <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      evten_q   <= '0;
      evt_q     <= 1'b0;
    end else begin
      keystat_q <= keystat_d;
      swstat_q  <= swstat_d;
      hex_q     <= hex_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      evten_q   <= evten_d;
      evt_q     <= evt_d;
    end
  end

  assign HEXVAL = hex_q;
  assign LEDR   = ledr_q;
  assign LEDG   = ledg_q;
  assign EVT    = evt_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl with DEB_CYCLES=4, active-low keys.
module tb_mmio_io_ctrl;

  logic        CLK;
  logic        RESET;
  logic [15:0] ADDR, WDATA, RDATA, HEXVAL;
  logic        WE, HIT, EVT;
  logic [3:0]  KEY;
  logic [9:0]  SW, LEDR;
  logic [7:0]  LEDG;

  mmio_io_ctrl #(.DEB_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WE(WE), .WDATA(WDATA),
    .RDATA(RDATA), .HIT(HIT), .KEY(KEY), .SW(SW), .LEDR(LEDR),
    .LEDG(LEDG), .HEXVAL(HEXVAL), .EVT(EVT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {K_RDATA, K_HIT, K_HEX, K_LEDR, K_LEDG, K_EVT} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    logic [15:0] exp;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_hit;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic logic [15:0] actual(input kind_e k);
    case (k)
      K_RDATA: return RDATA;
      K_HIT:   return {15'h0, HIT};
      K_HEX:   return HEXVAL;
      K_LEDR:  return {6'h0, LEDR};
      K_LEDG:  return {8'h0, LEDG};
      K_EVT:   return {15'h0, EVT};
      default: return 16'h0;
    endcase
  endfunction

  task automatic push(input kind_e k, input string nm, input logic [15:0] e);
    exp_t x;
    x.kind = k;
    x.name = nm;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t        x;
    logic [15:0] act;
    while (sb.size() > 0) begin
      x   = sb.pop_front();
      act = actual(x.kind);
      n_cmp++;
      if (act !== x.exp) begin
        n_mis++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", x.name, act, x.exp, $time);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input logic h, input string nm);
    ADDR = a;
    WE   = 1'b0;
    push(K_RDATA, nm, e);
    push(K_HIT, {nm, "_hit"}, {15'h0, h});
    #1;
    drain();
  endtask

  task automatic chk(input kind_e k, input string nm, input logic [15:0] e);
    push(k, nm, e);
    #1;
    drain();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ADDR  = a;
    WDATA = d;
    WE    = 1'b1;
    step();
    WE    = 1'b0;
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic w, input logic [15:0] d,
                              input logic [15:0] e, input logic h, input string nm);
    vec_t v;
    v.addr = a; v.we = w; v.wdata = d; v.exp_rdata = e; v.exp_hit = h; v.name = nm;
    return v;
  endfunction

  initial begin
    RESET = 1'b1;
    KEY   = 4'hF;
    SW    = 10'h000;
    ADDR  = 16'h0000;
    WDATA = 16'h0000;
    WE    = 1'b0;

    // Register map, window boundaries, truncation and read-only behaviour
    vecs.push_back(mk(16'hFFF0, 1'b0, 16'h0000, 16'h0000, 1'b1, "rst_keydata"));
    vecs.push_back(mk(16'hFFF2, 1'b0, 16'h0000, 16'h0000, 1'b1, "rst_swdata"));
    vecs.push_back(mk(16'hFFF4, 1'b0, 16'h0000, 16'h0000, 1'b1, "rst_keystat"));
    vecs.push_back(mk(16'hFFF6, 1'b0, 16'h0000, 16'h0000, 1'b1, "rst_swstat"));
    vecs.push_back(mk(16'hFFF8, 1'b0, 16'h0000, 16'h0000, 1'b1, "rst_hex"));
    vecs.push_back(mk(16'hFFFA, 1'b0, 16'h0000, 16'h0000, 1'b1, "rst_ledr"));
    vecs.push_back(mk(16'hFFFC, 1'b0, 16'h0000, 16'h0000, 1'b1, "rst_ledg"));
    vecs.push_back(mk(16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b1, "rst_evten"));
    vecs.push_back(mk(16'h0100, 1'b0, 16'h0000, 16'hDEAD, 1'b0, "miss_0100"));
    vecs.push_back(mk(16'hFFFF, 1'b0, 16'h0000, 16'hDEAD, 1'b0, "miss_ffff"));
    vecs.push_back(mk(16'hFFEE, 1'b0, 16'h0000, 16'hDEAD, 1'b0, "miss_ffee"));
    vecs.push_back(mk(16'hFFF8, 1'b1, 16'hBEEF, 16'hBEEF, 1'b1, "wr_hex"));
    vecs.push_back(mk(16'hFFFA, 1'b1, 16'h03FF, 16'h03FF, 1'b1, "wr_ledr"));
    vecs.push_back(mk(16'hFFFC, 1'b1, 16'h01FF, 16'h00FF, 1'b1, "wr_ledg_trunc"));
    vecs.push_back(mk(16'hFFF9, 1'b0, 16'h0000, 16'hBEEF, 1'b1, "odd_hex"));
    vecs.push_back(mk(16'hFFFD, 1'b0, 16'h0000, 16'h00FF, 1'b1, "odd_ledg"));
    vecs.push_back(mk(16'hFFF0, 1'b1, 16'h1234, 16'h0000, 1'b1, "wr_keydata_ro"));
    vecs.push_back(mk(16'hFFF2, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "wr_swdata_ro"));
    vecs.push_back(mk(16'hFFFE, 1'b1, 16'hFFFF, 16'h0003, 1'b1, "wr_evten_trunc"));
    vecs.push_back(mk(16'hFFFE, 1'b1, 16'h0000, 16'h0000, 1'b1, "wr_evten_clr"));
    vecs.push_back(mk(16'h0100, 1'b1, 16'hFFFF, 16'hDEAD, 1'b0, "wr_outside"));
    vecs.push_back(mk(16'hFFF4, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "w1c_empty"));

    // Outputs held at zero during reset
    #2;
    chk(K_HEX,  "rst_hexval", 16'h0000);
    chk(K_LEDR, "rst_ledr_port", 16'h0000);
    chk(K_LEDG, "rst_ledg_port", 16'h0000);
    chk(K_EVT,  "rst_evt", 16'h0000);
    step();
    step();
    RESET = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        wr(vecs[i].addr, vecs[i].wdata);
      end
      rd(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_hit, vecs[i].name);
      step();
    end
    chk(K_HEX,  "hexval_port", 16'hBEEF);
    chk(K_LEDR, "ledr_port", 16'h03FF);
    chk(K_LEDG, "ledg_port", 16'h00FF);

    // KEY[2] press: debounced on the 6th edge, EVT one edge later
    wr(16'hFFFE, 16'h0001);
    KEY = 4'hB;
    for (int e = 1; e <= 6; e++) begin
      step();
      rd(16'hFFF0, (e == 6) ? 16'h0004 : 16'h0000, 1'b1, "key2_data");
      rd(16'hFFF4, (e == 6) ? 16'h0004 : 16'h0000, 1'b1, "key2_stat");
      if (e == 6) chk(K_EVT, "evt_lag", 16'h0000);
    end
    step();
    chk(K_EVT, "evt_key", 16'h0001);
    KEY = 4'hF;
    repeat (8) step();
    rd(16'hFFF0, 16'h0000, 1'b1, "key_released");
    rd(16'hFFF4, 16'h0004, 1'b1, "keystat_sticky");
    chk(K_EVT, "evt_sticky", 16'h0001);

    // SW[9] 3-cycle glitch is rejected, then a held level is accepted
    SW = 10'h200;
    repeat (3) step();
    SW = 10'h000;
    repeat (8) step();
    rd(16'hFFF2, 16'h0000, 1'b1, "sw_glitch_data");
    rd(16'hFFF6, 16'h0000, 1'b1, "sw_glitch_stat");
    SW = 10'h200;
    for (int e = 1; e <= 6; e++) begin
      step();
      rd(16'hFFF2, (e == 6) ? 16'h0200 : 16'h0000, 1'b1, "sw9_data");
      rd(16'hFFF6, (e == 6) ? 16'h0200 : 16'h0000, 1'b1, "sw9_stat");
    end
    wr(16'hFFFE, 16'h0002);
    step();
    chk(K_EVT, "evt_sw", 16'h0001);
    wr(16'hFFF6, 16'h0200);
    rd(16'hFFF6, 16'h0000, 1'b1, "swstat_w1c");
    chk(K_EVT, "evt_clr_lag", 16'h0001);
    step();
    chk(K_EVT, "evt_clr", 16'h0000);
    SW = 10'h000;
    repeat (6) step();
    rd(16'hFFF2, 16'h0000, 1'b1, "sw9_fall_data");
    rd(16'hFFF6, 16'h0200, 1'b1, "sw9_fall_stat");
    chk(K_EVT, "evt_fall_lag", 16'h0000);
    step();
    chk(K_EVT, "evt_fall", 16'h0001);

    // W1C of one bit, then set-wins when clear and press share an edge
    wr(16'hFFF4, 16'h000F);
    rd(16'hFFF4, 16'h0000, 1'b1, "keystat_clr_all");
    KEY = 4'hA;
    repeat (6) step();
    rd(16'hFFF0, 16'h0005, 1'b1, "key02_data");
    rd(16'hFFF4, 16'h0005, 1'b1, "key02_stat");
    wr(16'hFFF4, 16'h0001);
    rd(16'hFFF4, 16'h0004, 1'b1, "keystat_w1c_bit0");
    KEY = 4'hF;
    repeat (8) step();
    rd(16'hFFF0, 16'h0000, 1'b1, "key02_release");
    rd(16'hFFF4, 16'h0004, 1'b1, "release_no_set");
    KEY = 4'hB;
    repeat (5) step();
    rd(16'hFFF0, 16'h0000, 1'b1, "key2_pre");
    wr(16'hFFF4, 16'h0004);
    rd(16'hFFF0, 16'h0004, 1'b1, "key2_again");
    rd(16'hFFF4, 16'h0004, 1'b1, "set_wins");
    wr(16'hFFF4, 16'h0004);
    rd(16'hFFF4, 16'h0000, 1'b1, "keystat_w1c_bit2");

    // Reset mid-debounce clears outputs and restarts the counter
    KEY = 4'hF;
    repeat (8) step();
    rd(16'hFFF0, 16'h0000, 1'b1, "pre_reset_key");
    KEY = 4'hB;
    repeat (4) step();
    RESET = 1'b1;
    chk(K_HEX,  "mid_rst_hex", 16'h0000);
    chk(K_LEDR, "mid_rst_ledr", 16'h0000);
    chk(K_LEDG, "mid_rst_ledg", 16'h0000);
    chk(K_EVT,  "mid_rst_evt", 16'h0000);
    rd(16'hFFFE, 16'h0000, 1'b1, "mid_rst_evten");
    step();
    RESET = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      rd(16'hFFF0, (e == 6) ? 16'h0004 : 16'h0000, 1'b1, "post_rst_key");
      if (e == 6) rd(16'hFFF4, 16'h0004, 1'b1, "post_rst_stat");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
